// File: rtl/npx_timer_pkg.sv
// Shared definitions for the NeoPixel timing counters: load-select names,
// default preset table and a preset range helper.
package npx_timer_pkg;

    typedef enum logic [2:0] {
        TIMER_35   = 3'd0,
        TIMER_30   = 3'd1,
        TIMER_18   = 3'd2,
        TIMER_40   = 3'd3,
        TIMER_2500 = 3'd4,
        TIMER_EXT  = 3'd7
    } timer_sel_t;

    localparam int unsigned DEFAULT_WIDTH   = 12;
    localparam int unsigned DEFAULT_PRESET0 = 35;    // 1-bit high time
    localparam int unsigned DEFAULT_PRESET1 = 30;    // 1-bit low time
    localparam int unsigned DEFAULT_PRESET2 = 18;    // 0-bit high time
    localparam int unsigned DEFAULT_PRESET3 = 40;    // 0-bit low time
    localparam int unsigned DEFAULT_PRESET4 = 2500;  // latch gap
    localparam int unsigned DEFAULT_PRESET5 = 0;
    localparam int unsigned DEFAULT_PRESET6 = 0;

    function automatic bit preset_fits(int unsigned value, int unsigned width);
        if (width >= 32) begin
            return 1'b1;
        end
        return (value >> width) == 0;
    endfunction

endpackage

// File: rtl/count_down_to_zero_mux8to1.sv
// Generic 8:1 multiplexer used to pick the counter load value.
module mux8to1 #(
    parameter int unsigned WIDTH = 12
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] y
);

    // NOTE: a full case with a default assignment first keeps this purely
    // combinational; any path leaving y unassigned would infer a latch.
    always_comb begin
        y = i0;
        unique case (s)
            3'd0: y = i0;
            3'd1: y = i1;
            3'd2: y = i2;
            3'd3: y = i3;
            3'd4: y = i4;
            3'd5: y = i5;
            3'd6: y = i6;
            3'd7: y = i7;
            default: y = i0;
        endcase
    end

endmodule

// File: rtl/count_down_to_zero.sv
// Loadable down-counter with preset mux and one-hot load strobe.
// Optional macro COUNT_DOWN_TO_ZERO_WRAP_EN: decrement at zero wraps to all-ones.
module count_down_to_zero
    import npx_timer_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned PRESET0 = DEFAULT_PRESET0,
    parameter int unsigned PRESET1 = DEFAULT_PRESET1,
    parameter int unsigned PRESET2 = DEFAULT_PRESET2,
    parameter int unsigned PRESET3 = DEFAULT_PRESET3,
    parameter int unsigned PRESET4 = DEFAULT_PRESET4,
    parameter int unsigned PRESET5 = DEFAULT_PRESET5,
    parameter int unsigned PRESET6 = DEFAULT_PRESET6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic [7:0]       load_onehot
);

    localparam int unsigned PRESETS [7] = '{PRESET0, PRESET1, PRESET2, PRESET3,
                                            PRESET4, PRESET5, PRESET6};

    // A preset that cannot be represented would silently truncate on load.
    for (genvar i = 0; i < 7; i++) begin : g_preset_chk
        if (!preset_fits(PRESETS[i], WIDTH)) begin : g_bad
            $error("count_down_to_zero: preset %0d (%0d) exceeds WIDTH=%0d",
                   i, PRESETS[i], WIDTH);
        end
    end

    logic [WIDTH-1:0] w_mux_y;
    logic [WIDTH-1:0] r_q;
    logic             w_zero;

    mux8to1 #(.WIDTH(WIDTH)) u_load_mux (
        .i0 (WIDTH'(PRESET0)),
        .i1 (WIDTH'(PRESET1)),
        .i2 (WIDTH'(PRESET2)),
        .i3 (WIDTH'(PRESET3)),
        .i4 (WIDTH'(PRESET4)),
        .i5 (WIDTH'(PRESET5)),
        .i6 (WIDTH'(PRESET6)),
        .i7 (d),
        .s  (sel),
        .y  (w_mux_y)
    );

    assign w_zero = (r_q == '0);

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_mux_y;
        end else if (en) begin
            if (!w_zero) begin
                r_q <= r_q - WIDTH'(1);
            end else begin
`ifdef COUNT_DOWN_TO_ZERO_WRAP_EN
                r_q <= '1;
`else
                r_q <= '0;
`endif
            end
        end
    end

    assign q           = r_q;
    assign done        = w_zero;
    assign load_onehot = load ? (8'b1 << sel) : 8'b0;

endmodule

// File: tb/tb_count_down_to_zero.sv
// Randomised self-checking bench for count_down_to_zero against an
// arithmetic reference model of the counter rules.
module tb_count_down_to_zero;

    localparam int W    = 12;
    localparam int MAXV = (1 << W) - 1;

`ifdef COUNT_DOWN_TO_ZERO_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         load;
    logic         en;
    logic [2:0]   sel;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         done;
    logic [7:0]   load_onehot;

    int n_total = 0;
    int n_pass  = 0;
    int model_q = 0;
    int preset_tab [7] = '{35, 30, 18, 40, 2500, 0, 0};

    count_down_to_zero dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .en          (en),
        .sel         (sel),
        .d           (d),
        .q           (q),
        .done        (done),
        .load_onehot (load_onehot)
    );

    always #5 clock = ~clock;

    function automatic int model_next(int cur, bit rst, bit ld, bit e, int s, int dv);
        if (rst) return 0;
        if (ld)  return (s == 7) ? dv : preset_tab[s];
        if (e) begin
            if (cur > 0) return cur - 1;
            return WRAP ? MAXV : 0;
        end
        return cur;
    endfunction

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic tick();
        int nxt;
        nxt = model_next(model_q, reset, load, en, int'(sel), int'(d));
        @(posedge clock);
        #1;
        model_q = nxt;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; en = 1'b0; sel = 3'd4; d = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (q !== W'(0)) $display("FAIL reset_q: q=%0d expected 0", q);
            else n_pass++;
            n_total++;
            if (done !== 1'b1) $display("FAIL reset_done: done=%0b expected 1", done);
            else n_pass++;
        end
        reset = 1'b0; load = 1'b0;
        #1;
        n_total++;
        if (load_onehot !== 8'h00) $display("FAIL reset_onehot: got %02h expected 00", load_onehot);
        else n_pass++;
    endtask

    task automatic test_preset_timing();
        int cycles;
        load = 1'b1; sel = 3'd0; en = 1'b0;
        tick();
        load = 1'b0;
        n_total++;
        if (q !== W'(35)) $display("FAIL preset_load: q=%0d expected 35", q);
        else n_pass++;
        en = 1'b1;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cycles++;
            n_total++;
            if (q !== W'(model_q)) $display("FAIL preset_count: q=%0d expected %0d", q, model_q);
            else n_pass++;
            if (done === 1'b1) break;
        end
        en = 1'b0;
        n_total++;
        if (cycles != 35) $display("FAIL preset_done_time: took %0d cycles expected 35", cycles);
        else n_pass++;
    endtask

    task automatic test_external();
        load = 1'b1; sel = 3'd7; d = W'(408); en = 1'b0;
        tick();
        load = 1'b0; d = W'($urandom);
        n_total++;
        if (q !== W'(408)) $display("FAIL ext_load: q=%0d expected 408", q);
        else n_pass++;
        for (int p = 1; p <= 408; p++) begin
            int gap;
            gap = $urandom_range(0, 2);
            en = 1'b0;
            sel = 3'($urandom);
            for (int g = 0; g < gap; g++) tick();
            en = 1'b1;
            tick();
            en = 1'b0;
            n_total++;
            if (q !== W'(model_q) || done !== (p == 408))
                $display("FAIL ext_pulse%0d: q=%0d done=%0b expected q=%0d done=%0b",
                         p, q, done, model_q, (p == 408));
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        load = 1'b1; en = 1'b1; sel = 3'd2;
        tick();
        load = 1'b0;
        n_total++;
        if (q !== W'(18)) $display("FAIL prio_load_en: q=%0d expected 18", q);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_total++;
        if (q !== W'(15)) $display("FAIL prio_count: q=%0d expected 15", q);
        else n_pass++;
        reset = 1'b1; load = 1'b1; sel = 3'd4;
        tick();
        reset = 1'b0; load = 1'b0; en = 1'b0;
        n_total++;
        if (q !== W'(0) || done !== 1'b1)
            $display("FAIL prio_reset: q=%0d done=%0b expected q=0 done=1", q, done);
        else n_pass++;
    endtask

    task automatic test_zero_boundary();
        int exp_q;
        en = 1'b1; load = 1'b0;
        tick();
        exp_q = WRAP ? MAXV : 0;
        n_total++;
        if (q !== W'(exp_q) || done !== (exp_q == 0))
            $display("FAIL zero_en: q=%0d done=%0b expected q=%0d done=%0b",
                     q, done, exp_q, (exp_q == 0));
        else n_pass++;
        tick();
        exp_q = WRAP ? MAXV - 1 : 0;
        n_total++;
        if (q !== W'(exp_q)) $display("FAIL zero_next: q=%0d expected %0d", q, exp_q);
        else n_pass++;
        en = 1'b0;
        load = 1'b1; sel = 3'd5;
        tick();
        load = 1'b0;
        n_total++;
        if (q !== W'(0) || done !== 1'b1)
            $display("FAIL zero_load0: q=%0d done=%0b expected q=0 done=1", q, done);
        else n_pass++;
    endtask

    task automatic test_decoder();
        en = 1'b0;
        for (int s = 0; s < 8; s++) begin
            load = 1'b1; sel = 3'(s); d = W'($urandom);
            #1;
            n_total++;
            if (load_onehot !== 8'(1 << s))
                $display("FAIL dec_on_sel%0d: got %02h expected %02h", s, load_onehot, 8'(1 << s));
            else n_pass++;
            tick();
            n_total++;
            if (q !== W'(model_q)) $display("FAIL dec_load_sel%0d: q=%0d expected %0d", s, q, model_q);
            else n_pass++;
            load = 1'b0;
            #1;
            n_total++;
            if (load_onehot !== 8'h00) $display("FAIL dec_off_sel%0d: got %02h expected 00", s, load_onehot);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            sel   = 3'($urandom);
            d     = W'($urandom_range(0, 40));
            #1;
            n_total++;
            if (load_onehot !== (load ? 8'(1 << int'(sel)) : 8'h00))
                $display("FAIL rand_onehot%0d: got %02h load=%0b sel=%0d", i, load_onehot, load, sel);
            else n_pass++;
            tick();
            n_total++;
            if (q !== W'(model_q) || done !== (model_q == 0))
                $display("FAIL rand_q%0d: q=%0d done=%0b expected q=%0d done=%0b",
                         i, q, done, model_q, (model_q == 0));
            else n_pass++;
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_preset_timing();
        test_external();
        test_priority();
        test_zero_boundary();
        test_decoder();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
